serial_tx_shifter: RTL
======================

# serial_tx_shifter

Byte-wide to bit-serial transmitter that frames a parallel byte as an asynchronous serial character: start bit, 8 data bits LSB first, stop bit. It sits directly downstream of the parallel logic built from the cell library and upstream of the board's single output pin/LED. It is sized so that its synthesized netlist maps onto the buffer, and, or, xor, nand, not, mux and dff cells only, with no memories.

## Interface
- DIV, default 4: clock cycles per serial bit; legal range 1..16.
- DATA_W, default 8: data bits per frame; fixed at 8 for this revision.

- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- data  in  8  byte to send; sampled only on the accept edge.
- valid  in  1  upstream has a byte on data.
- ready  out  1  block can accept a byte this cycle.
- tx  out  1  serial line; idle/mark level is 1.
- busy  out  1  a frame is in progress; equals !ready.

Clock and reset are as decided: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- **Reset.** While rst is high at a clk edge, the block loads:
  - state=IDLE, tx=1, ready=1, busy=0;
  - bit counter=0, divider counter=0, shift register=0x00.
- **Reset priority.** rst overrides every other input on the same edge.
- **Registered outputs.** All outputs come directly from flops (dff q/notq), with no combinational path from inputs to outputs. ready is a flop, not a decode of valid.
- **Accept.** A byte is accepted on an edge where valid=1 and ready=1. data goes into the shift register and the block moves to START. If valid=1 while ready=0, the byte is ignored; upstream must hold it.
- **States:**
  - IDLE: tx=1, ready=1. Accept leads to START.
  - START: tx=0 for DIV cycles, then DATA with bit counter=0.
  - DATA: tx=shift[0] for DIV cycles per bit. At each bit end, shift right by 1 and increment the bit counter. After bit 7 ends, go to STOP.
  - STOP: tx=1 for DIV cycles. At its end go to IDLE with ready=1.
- **Counters:**
  - Divider counter is 4 bits and counts 0..DIV-1. The bit period ends when counter==DIV-1, and the counter wraps to 0. With DIV=1 every cycle is a bit end.
  - Bit counter is 3 bits, 0..7. Its wrap from 7 is the DATA->STOP condition.
- **Data capture.** data changing after the accept edge has no effect on the current frame.

## Timing
- **Accept to line.** With the accept at edge E0, tx=0 is visible from E0 until E0+DIV.
- **Data bits.** Data bit i is on tx from E0+(1+i)·DIV to E0+(2+i)·DIV.
- **Stop bit.** The stop bit runs from E0+9·DIV to E0+10·DIV.
- **Frame length.** ready=0 and busy=1 from E0 to E0+10·DIV. ready=1 is visible after edge E0+10·DIV.
- **Back-to-back.** If valid is held high, the next accept happens at E0+10·DIV+1. That gives exactly one extra idle (tx=1) clock between frames, so the sustained rate is one byte per 10·DIV+1 cycles.
- **Latency.** From accept to first start-bit level on tx: 1 clock, registered.
- **Reset mid-frame.** At any cycle, rst=1 gives tx=1, ready=1 after that edge. The partial frame is abandoned and not resumed.
- **Reset with valid.** rst=1 together with valid=1 causes no accept.
- **Glitch-free line.** tx must not glitch between bits, since it drives a discrete pin; it is a single flop output.

## Test plan
- **Reset values.** Hold rst 3 cycles with valid=1 and data=0xFF, then release. Required: tx=1, ready=1, busy=0, and no frame starts until valid is sampled after release.
- **Single frame, DIV=4.** Send data=0xA5. Required tx sequence, 4 clocks each: 0, 1,0,1,0,0,1,0,1, 1. Also required: ready=0 for exactly 40 cycles, and a monitor decodes 0xA5.
- **Back-to-back, DIV=1.** Hold valid=1 with data=0x00 then 0xFF. Required: frames of 10 cycles separated by exactly 1 idle tx=1 cycle. Decoded bytes are 0x00 then 0xFF.
- **Ignored valid while busy.** Send 0x3C, then pulse valid with data=0x99 mid-frame. Required: only 0x3C is transmitted, and ready stays 0 through the pulse.
- **Reset mid-frame, DIV=4.** Send 0x0F and assert rst at cycle 17, during data bit 3. Required: tx=1 and ready=1 on the next cycle. A fresh 0x81 sent afterwards decodes correctly.
- **Data change after accept.** Accept 0x55, then change data to 0xAA on the next cycle. Required: transmitted byte is 0x55.

Source files
------------

// File: rtl/serial_tx_shifter.sv
// Byte-to-serial transmitter: frames a byte as start bit, 8 data bits LSB first, stop bit.
// Every output is a flop, so tx is glitch-free and ready never depends on valid combinationally.
module serial_tx_shifter #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [3:0]        div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    bit_end = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        if (valid && ready_q) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        div_d = bit_end ? '0 : 4'(div_q + 4'd1);
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        div_d = bit_end ? '0 : 4'(div_q + 4'd1);
        // tx is loaded one bit ahead so the line changes exactly on the bit boundary
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = 3'(bit_q + 3'd1);
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        div_d = bit_end ? '0 : 4'(div_q + 4'd1);
        if (bit_end) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    busy_d = !ready_d;
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule
